// File: rtl/rv32imf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_pkg
// Description : Shared APU widths and arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32imf_pkg;

    localparam int APU_NARGS    = 3;
    localparam int APU_WOP      = 6;
    localparam int APU_NDSFLAGS = 15;
    localparam int APU_NUSFLAGS = 5;
    localparam int APU_DATA_W   = 32;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } apu_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rv32imf_apu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_apu_arbiter_if
// Description : Request/response channel between the arbiter and the FP unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32imf_apu_arbiter_if;
    import rv32imf_pkg::*;

    logic                                 apu_req_o;
    logic                                 apu_gnt_i;
    logic [APU_NARGS-1:0][APU_DATA_W-1:0] apu_operands_o;
    logic [APU_WOP-1:0]                   apu_op_o;
    logic [APU_NDSFLAGS-1:0]              apu_flags_o;
    logic                                 apu_rvalid_i;
    logic [APU_DATA_W-1:0]                apu_result_i;
    logic [APU_NUSFLAGS-1:0]              apu_flags_i;

    modport master (
        output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
        input  apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i
    );

    modport slave (
        input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
        output apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i
    );

endinterface
`default_nettype wire

// File: rtl/rv32imf_apu_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_apu_tag_fifo
// Description : In-order FIFO of requester tags for granted APU operations.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32imf_apu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == CW'(DEPTH));
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign head_o    = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32imf_apu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_apu_arbiter
// Description : Round-robin arbiter sharing one in-order FP unit among cores.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32imf_apu_arbiter
    import rv32imf_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_OUTST = 4
) (
    input  wire logic                                              clk_i,
    input  wire logic                                              rst_ni,
    input  wire logic [NUM_REQ-1:0]                                req_i,
    output logic      [NUM_REQ-1:0]                                gnt_o,
    input  wire logic [NUM_REQ-1:0][APU_NARGS-1:0][APU_DATA_W-1:0] operands_i,
    input  wire logic [NUM_REQ-1:0][APU_WOP-1:0]                   op_i,
    input  wire logic [NUM_REQ-1:0][APU_NDSFLAGS-1:0]              flags_i,
    output logic      [NUM_REQ-1:0]                                rvalid_o,
    output logic      [APU_DATA_W-1:0]                             result_o,
    output logic      [APU_NUSFLAGS-1:0]                           rflags_o,
    rv32imf_apu_arbiter_if.master                                  apu,
    output logic                                                   busy_o,
    output logic                                                   spurious_o
);

    localparam int IW = $clog2(NUM_REQ);

    apu_arb_state_e r_state;
    apu_arb_state_e w_state_nxt;
    logic [IW-1:0]  r_rr_ptr;
    logic [IW-1:0]  w_rr_ptr_nxt;
    logic [IW-1:0]  r_lock_sel;
    logic [IW-1:0]  w_lock_sel_nxt;

    logic [NUM_REQ-1:0] w_req_rot;
    logic [IW-1:0]      w_ofs;
    logic [IW:0]        w_sum;
    logic [IW-1:0]      w_arb_sel;
    logic [IW-1:0]      w_sel;
    logic               w_apu_req;
    logic               w_hold_drop;
    logic               w_rsp_spurious;
    logic               w_push;
    logic               w_pop;
    logic [IW-1:0]      w_head;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the round-robin winner
    always_comb begin
        w_req_rot = NUM_REQ'({req_i, req_i} >> r_rr_ptr);
        w_ofs     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_ofs = IW'(i);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
        if (w_sum >= (IW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IW+1)'(NUM_REQ);
        end
        w_arb_sel = w_sum[IW-1:0];
    end

    // Request/response qualification; everything is silenced while in reset
    always_comb begin
        w_sel       = (r_state == HOLD) ? r_lock_sel : w_arb_sel;
        w_apu_req   = 1'b0;
        w_hold_drop = 1'b0;
        if (rst_ni) begin
            if (r_state == HOLD) begin
                w_apu_req   = req_i[r_lock_sel];
                w_hold_drop = !req_i[r_lock_sel];
            end else begin
                w_apu_req   = (|req_i) && !w_fifo_full;
            end
        end
        w_push         = w_apu_req && apu.apu_gnt_i;
        w_pop          = rst_ni && apu.apu_rvalid_i && !w_fifo_empty;
        w_rsp_spurious = rst_ni && apu.apu_rvalid_i && w_fifo_empty;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_sel_nxt = r_lock_sel;
        w_rr_ptr_nxt   = r_rr_ptr;
        case (r_state)
            ARB: begin
                if (w_apu_req && !apu.apu_gnt_i) begin
                    w_state_nxt    = HOLD;
                    w_lock_sel_nxt = w_arb_sel;
                end
            end
            HOLD: begin
                if (w_hold_drop || w_push) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
        if (w_push) begin
            w_rr_ptr_nxt = (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_sel <= w_lock_sel_nxt;
        end
    end

    rv32imf_apu_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (w_push) begin
            gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            rvalid_o[w_head] = 1'b1;
        end
    end

    assign apu.apu_req_o      = w_apu_req;
    assign apu.apu_operands_o = operands_i[w_sel];
    assign apu.apu_op_o       = op_i[w_sel];
    assign apu.apu_flags_o    = flags_i[w_sel];

    assign result_o   = apu.apu_result_i;
    assign rflags_o   = apu.apu_flags_i;
    assign busy_o     = !w_fifo_empty || w_apu_req;
    assign spurious_o = w_hold_drop || w_rsp_spurious;

endmodule
`default_nettype wire

// File: tb/tb_rv32imf_apu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32imf_apu_arbiter
// Description : Directed self-checking bench for rv32imf_apu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32imf_apu_arbiter;
    import rv32imf_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int MAX_OUTST = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic [1:0]              req_i;
    logic [1:0]              gnt_o;
    logic [1:0][2:0][31:0]   operands_i;
    logic [1:0][5:0]         op_i;
    logic [1:0][14:0]        flags_i;
    logic [1:0]              rvalid_o;
    logic [31:0]             result_o;
    logic [4:0]              rflags_o;
    logic                    busy_o;
    logic                    spurious_o;

    int n_tests = 0;
    int n_fail  = 0;

    rv32imf_apu_arbiter_if apu_if ();

    rv32imf_apu_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .operands_i (operands_i),
        .op_i       (op_i),
        .flags_i    (flags_i),
        .rvalid_o   (rvalid_o),
        .result_o   (result_o),
        .rflags_o   (rflags_o),
        .apu        (apu_if.master),
        .busy_o     (busy_o),
        .spurious_o (spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv);
        req_i               = req;
        apu_if.apu_gnt_i    = gnt;
        apu_if.apu_rvalid_i = rv;
        #1;
    endtask

    initial begin
        rst_ni              = 1'b0;
        req_i               = 2'b00;
        apu_if.apu_gnt_i    = 1'b0;
        apu_if.apu_rvalid_i = 1'b0;
        apu_if.apu_result_i = 32'hDEAD_BEEF;
        apu_if.apu_flags_i  = 5'h15;
        op_i[0]             = 6'h11;
        op_i[1]             = 6'h22;
        flags_i[0]          = 15'h1111;
        flags_i[1]          = 15'h2222;
        for (int k = 0; k < 3; k++) begin
            operands_i[0][k] = 32'hA000_0000 + k;
            operands_i[1][k] = 32'hB000_0000 + k;
        end

        // reset holds every control output low even with live stimulus
        next_cycle();
        drive(2'b11, 1'b1, 1'b1);
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_rvalid", rvalid_o, 2'b00);
        check("rst_apu_req", apu_if.apu_req_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_spurious", spurious_o, 1'b0);
        check("pass_result", result_o, 32'hDEAD_BEEF);
        check("pass_rflags", rflags_o, 5'h15);
        next_cycle();
        rst_ni = 1'b1;
        drive(2'b00, 1'b0, 1'b0);
        check("idle_busy", busy_o, 1'b0);

        // response with nothing in flight
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("spur_empty", spurious_o, 1'b1);
        check("spur_empty_rvalid", rvalid_o, 2'b00);
        next_cycle(); drive(2'b00, 1'b0, 1'b0);
        check("spur_one_cycle", spurious_o, 1'b0);

        // both requesting, responses one cycle behind
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("rr_gnt0", gnt_o, 2'b01);
        check("rr_op0", apu_if.apu_op_o, 6'h11);
        check("rr_opnd0", apu_if.apu_operands_o[2], 32'hA000_0002);
        check("rr_flags0", apu_if.apu_flags_o, 15'h1111);
        next_cycle(); drive(2'b11, 1'b1, 1'b1);
        check("rr_gnt1", gnt_o, 2'b10);
        check("rr_op1", apu_if.apu_op_o, 6'h22);
        check("rr_rv1", rvalid_o, 2'b01);
        next_cycle(); drive(2'b11, 1'b1, 1'b1);
        check("rr_gnt2", gnt_o, 2'b01);
        check("rr_rv2", rvalid_o, 2'b10);
        next_cycle(); drive(2'b11, 1'b1, 1'b1);
        check("rr_gnt3", gnt_o, 2'b10);
        check("rr_rv3", rvalid_o, 2'b01);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("rr_gnt4", gnt_o, 2'b00);
        check("rr_rv4", rvalid_o, 2'b10);
        check("rr_busy", busy_o, 1'b1);
        next_cycle(); drive(2'b00, 1'b0, 1'b0);
        check("rr_drained", busy_o, 1'b0);

        // stalled grant keeps requester 0 locked while requester 1 arrives
        next_cycle(); drive(2'b01, 1'b0, 1'b0);
        check("hold_req", apu_if.apu_req_o, 1'b1);
        check("hold_op_c0", apu_if.apu_op_o, 6'h11);
        check("hold_gnt_c0", gnt_o, 2'b00);
        next_cycle(); drive(2'b11, 1'b0, 1'b0);
        check("hold_op_c1", apu_if.apu_op_o, 6'h11);
        next_cycle(); drive(2'b11, 1'b0, 1'b0);
        check("hold_op_c2", apu_if.apu_op_o, 6'h11);
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("hold_op_c3", apu_if.apu_op_o, 6'h11);
        check("hold_gnt_c3", gnt_o, 2'b01);
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("hold_next_op", apu_if.apu_op_o, 6'h22);
        check("hold_next_gnt", gnt_o, 2'b10);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("hold_rv0", rvalid_o, 2'b01);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("hold_rv1", rvalid_o, 2'b10);
        next_cycle(); drive(2'b00, 1'b0, 0);
        check("hold_drained", busy_o, 1'b0);

        // locked requester withdraws mid-hold
        next_cycle(); drive(2'b01, 1'b0, 1'b0);
        check("drop_req", apu_if.apu_req_o, 1'b1);
        next_cycle(); drive(2'b00, 1'b0, 1'b0);
        check("drop_apu_req", apu_if.apu_req_o, 1'b0);
        check("drop_spurious", spurious_o, 1'b1);
        check("drop_gnt", gnt_o, 2'b00);
        next_cycle(); drive(2'b10, 1'b1, 1'b0);
        check("drop_rearb_gnt", gnt_o, 2'b10);
        check("drop_spur_clear", spurious_o, 1'b0);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("drop_rv", rvalid_o, 2'b10);
        next_cycle(); drive(2'b00, 1'b0, 1'b0);

        // fill to MAX_OUTST, then a same-cycle pop must not admit a push
        for (int i = 0; i < 4; i++) begin
            next_cycle(); drive(2'b11, 1'b1, 1'b0);
            check("full_fill_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("full_apu_req", apu_if.apu_req_o, 1'b0);
        check("full_gnt", gnt_o, 2'b00);
        check("full_busy", busy_o, 1'b1);
        next_cycle(); drive(2'b11, 1'b1, 1'b1);
        check("full_pop_apu_req", apu_if.apu_req_o, 1'b0);
        check("full_pop_gnt", gnt_o, 2'b00);
        check("full_pop_rv", rvalid_o, 2'b01);
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("full_after_req", apu_if.apu_req_o, 1'b1);
        check("full_after_gnt", gnt_o, 2'b01);

        // queue holds tags 1,0,1,0: drain two, then push+pop at depth 2
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("pp_rv_a", rvalid_o, 2'b10);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("pp_rv_b", rvalid_o, 2'b01);
        next_cycle(); drive(2'b11, 1'b1, 1'b1);
        check("pp_gnt", gnt_o, 2'b10);
        check("pp_rv_oldest", rvalid_o, 2'b10);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("pp_rv_c", rvalid_o, 2'b01);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("pp_rv_d", rvalid_o, 2'b10);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("pp_count2_spur", spurious_o, 1'b1);
        check("pp_count2_rv", rvalid_o, 2'b00);
        next_cycle(); drive(2'b00, 1'b0, 1'b0);
        check("pp_drained", busy_o, 1'b0);

        // reset with three operations in flight
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("mr_gnt0", gnt_o, 2'b01);
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("mr_gnt1", gnt_o, 2'b10);
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("mr_gnt2", gnt_o, 2'b01);
        next_cycle(); drive(2'b00, 1'b0, 1'b0);
        check("mr_busy", busy_o, 1'b1);
        rst_ni = 1'b0;
        drive(2'b11, 1'b1, 1'b1);
        check("mr_in_rst_busy", busy_o, 1'b0);
        check("mr_in_rst_gnt", gnt_o, 2'b00);
        check("mr_in_rst_rv", rvalid_o, 2'b00);
        check("mr_in_rst_apu_req", apu_if.apu_req_o, 1'b0);
        check("mr_in_rst_spur", spurious_o, 1'b0);
        next_cycle();
        rst_ni = 1'b1;
        drive(2'b00, 1'b0, 1'b0);
        check("mr_post_busy", busy_o, 1'b0);
        next_cycle(); drive(2'b00, 1'b0, 1'b1);
        check("mr_post_spur", spurious_o, 1'b1);
        check("mr_post_rv", rvalid_o, 2'b00);
        next_cycle(); drive(2'b11, 1'b1, 1'b0);
        check("mr_post_rr", gnt_o, 2'b01);
        next_cycle(); drive(2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
